// File: rtl/noc_link_pipe_monitor.sv
// Pipelined credit-based NoC link: NUM_PIPELINE register stages on the flit bundle
// and on the returning credit, plus upstream credit, framing and traffic monitoring.
module noc_link_pipe_monitor #(
    parameter  int unsigned NUM_PIPELINE      = 2,
    parameter  int unsigned FLIT_WIDTH        = 64,
    parameter  int unsigned DEST_WIDTH        = 6,
    parameter  int unsigned FLIT_BUFFER_DEPTH = 2,
    parameter  int unsigned CNT_WIDTH         = 16,
    localparam int unsigned CRD_W             = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic [CRD_W-1:0]      credits_avail,
    output logic                  in_packet,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  err_underflow,
    output logic                  err_overflow
);

    localparam int unsigned FWD_W = FLIT_WIDTH + DEST_WIDTH + 2;
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } state_e;

    logic [FWD_W-1:0] fwd_in;
    logic [FWD_W-1:0] fwd_out;

    assign fwd_in = {data_in, dest_in, is_tail_in, send_in};
    assign {data_out, dest_out, is_tail_out, send_out} = fwd_out;

    generate
        if (NUM_PIPELINE == 0) begin : g_wire
            assign fwd_out    = fwd_in;
            assign credit_out = credit_in;
        end else begin : g_pipe
            logic [FWD_W-1:0]        fwd_q [NUM_PIPELINE];
            logic [NUM_PIPELINE-1:0] crd_q;

            always_ff @(posedge clk_noc or posedge rst_noc) begin
                if (rst_noc) begin
                    for (int unsigned i = 0; i < NUM_PIPELINE; i++) begin
                        fwd_q[i] <= '0;
                    end
                    crd_q <= '0;
                end else begin
                    fwd_q[0] <= fwd_in;
                    crd_q[0] <= credit_in;
                    for (int unsigned i = 1; i < NUM_PIPELINE; i++) begin
                        fwd_q[i] <= fwd_q[i-1];
                        crd_q[i] <= crd_q[i-1];
                    end
                end
            end

            assign fwd_out    = fwd_q[NUM_PIPELINE-1];
            assign credit_out = crd_q[NUM_PIPELINE-1];
        end
    endgenerate

    // Upstream credit balance; a send and a returning credit in one cycle cancel.
    logic [CRD_W-1:0] avail_q, avail_d;
    logic             undf_q, undf_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        avail_d = avail_q;
        undf_d  = undf_q;
        ovf_d   = ovf_q;
        unique case ({send_in, credit_out})
            2'b10: begin
                if (avail_q == '0) begin
                    undf_d = 1'b1;
                end else begin
                    avail_d = avail_q - CRD_W'(1);
                end
            end
            2'b01: begin
                if (avail_q == CRD_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    avail_d = avail_q + CRD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            avail_q <= CRD_MAX;
            undf_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            avail_q <= avail_d;
            undf_q  <= undf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign credits_avail = avail_q;
    assign err_underflow = undf_q;
    assign err_overflow  = ovf_q;

    logic [CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        flit_cnt_d = flit_cnt_q + CNT_WIDTH'(send_in);
        pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(send_in & is_tail_in);
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign flit_count = flit_cnt_q;
    assign pkt_count  = pkt_cnt_q;

    state_e state_q, state_d;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A single-flit packet (head is also tail) never leaves IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (send_in && !is_tail_in) state_d = ST_PKT;
            ST_PKT:  if (send_in && is_tail_in)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_packet = (state_q == ST_PKT);
    end

endmodule

// File: tb/tb_noc_link_pipe_monitor.sv
// Scoreboard bench: two-stage link (main) and zero-stage link with 4-bit counters.
module tb_noc_link_pipe_monitor;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic [5:0]  dest;
        logic        tail;
    } flit_t;

    typedef struct {
        int          cyc;
        int          f;
        logic [31:0] v;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [63:0] a_data = '0;
    logic [5:0]  a_dest = '0;
    logic        a_tail = 1'b0, a_send = 1'b0, a_crin = 1'b0;
    logic        a_crout, a_tailout, a_sendout, a_inpkt, a_uf, a_of;
    logic [63:0] a_dout;
    logic [5:0]  a_destout;
    logic [1:0]  a_avail;
    logic [15:0] a_fc, a_pc;

    logic [63:0] b_data = '0;
    logic [5:0]  b_dest = '0;
    logic        b_tail = 1'b0, b_send = 1'b0, b_crin = 1'b0;
    logic        b_crout, b_tailout, b_sendout, b_inpkt, b_uf, b_of;
    logic [63:0] b_dout;
    logic [5:0]  b_destout;
    logic [1:0]  b_avail;
    logic [3:0]  b_fc, b_pc;

    flit_t fqa[$];
    flit_t fqb[$];
    int    cqa[$];
    int    cqb[$];
    st_t   sq[$];

    noc_link_pipe_monitor #(
        .NUM_PIPELINE(2), .FLIT_WIDTH(64), .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(2), .CNT_WIDTH(16)
    ) dut_a (
        .clk_noc(clk), .rst_noc(rst),
        .data_in(a_data), .dest_in(a_dest), .is_tail_in(a_tail), .send_in(a_send),
        .credit_out(a_crout),
        .data_out(a_dout), .dest_out(a_destout), .is_tail_out(a_tailout), .send_out(a_sendout),
        .credit_in(a_crin),
        .credits_avail(a_avail), .in_packet(a_inpkt),
        .flit_count(a_fc), .pkt_count(a_pc),
        .err_underflow(a_uf), .err_overflow(a_of)
    );

    noc_link_pipe_monitor #(
        .NUM_PIPELINE(0), .FLIT_WIDTH(64), .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(2), .CNT_WIDTH(4)
    ) dut_b (
        .clk_noc(clk), .rst_noc(rst),
        .data_in(b_data), .dest_in(b_dest), .is_tail_in(b_tail), .send_in(b_send),
        .credit_out(b_crout),
        .data_out(b_dout), .dest_out(b_destout), .is_tail_out(b_tailout), .send_out(b_sendout),
        .credit_in(b_crin),
        .credits_avail(b_avail), .in_packet(b_inpkt),
        .flit_count(b_fc), .pkt_count(b_pc),
        .err_underflow(b_uf), .err_overflow(b_of)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fval(input int f);
        case (f)
            0:  return 32'(a_avail);
            1:  return 32'(a_inpkt);
            2:  return 32'(a_fc);
            3:  return 32'(a_pc);
            4:  return 32'(a_uf);
            5:  return 32'(a_of);
            6:  return 32'(a_sendout);
            7:  return 32'(a_crout);
            8:  return a_dout[31:0];
            9:  return 32'(a_destout);
            10: return 32'(a_tailout);
            11: return 32'(b_fc);
            12: return 32'(b_pc);
            13: return 32'(b_avail);
            14: return 32'(b_inpkt);
            15: return 32'(b_uf);
            16: return 32'(b_of);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            0: return "a_avail";    1: return "a_in_packet"; 2: return "a_flit_count";
            3: return "a_pkt_count"; 4: return "a_err_underflow"; 5: return "a_err_overflow";
            6: return "a_send_out"; 7: return "a_credit_out"; 8: return "a_data_out";
            9: return "a_dest_out"; 10: return "a_is_tail_out"; 11: return "b_flit_count";
            12: return "b_pkt_count"; 13: return "b_avail"; 14: return "b_in_packet";
            15: return "b_err_underflow"; 16: return "b_err_overflow";
            default: return "unknown";
        endcase
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        flit_t e;
        if (a_sendout) begin
            checks++;
            if (fqa.size() == 0) begin
                errors++;
                $display("FAIL flit_a unexpected at cyc %0d: data=%h", cyc, a_dout);
            end else begin
                e = fqa.pop_front();
                if (e.cyc != cyc || a_dout !== e.data || a_destout !== e.dest || a_tailout !== e.tail) begin
                    errors++;
                    $display("FAIL flit_a: got cyc=%0d data=%h dest=%0d tail=%b, want cyc=%0d data=%h dest=%0d tail=%b",
                             cyc, a_dout, a_destout, a_tailout, e.cyc, e.data, e.dest, e.tail);
                end
            end
        end
        if (b_sendout) begin
            checks++;
            if (fqb.size() == 0) begin
                errors++;
                $display("FAIL flit_b unexpected at cyc %0d: data=%h", cyc, b_dout);
            end else begin
                e = fqb.pop_front();
                if (e.cyc != cyc || b_dout !== e.data || b_destout !== e.dest || b_tailout !== e.tail) begin
                    errors++;
                    $display("FAIL flit_b: got cyc=%0d data=%h dest=%0d tail=%b, want cyc=%0d data=%h dest=%0d tail=%b",
                             cyc, b_dout, b_destout, b_tailout, e.cyc, e.data, e.dest, e.tail);
                end
            end
        end
    end

    always @(negedge clk) begin
        int c;
        if (a_crout) begin
            checks++;
            if (cqa.size() == 0) begin
                errors++;
                $display("FAIL credit_a unexpected at cyc %0d", cyc);
            end else begin
                c = cqa.pop_front();
                if (c != cyc) begin
                    errors++;
                    $display("FAIL credit_a: got cyc=%0d want cyc=%0d", cyc, c);
                end
            end
        end
        if (b_crout) begin
            checks++;
            if (cqb.size() == 0) begin
                errors++;
                $display("FAIL credit_b unexpected at cyc %0d", cyc);
            end else begin
                c = cqb.pop_front();
                if (c != cyc) begin
                    errors++;
                    $display("FAIL credit_b: got cyc=%0d want cyc=%0d", cyc, c);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].cyc <= cyc) begin
                checks++;
                if (sq[i].cyc < cyc || fval(sq[i].f) !== sq[i].v) begin
                    errors++;
                    $display("FAIL %s at cyc %0d: got %0d want %0d (due cyc %0d)",
                             fname(sq[i].f), cyc, fval(sq[i].f), sq[i].v, sq[i].cyc);
                end
                sq.delete(i);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_next(input int f, input logic [31:0] v);
        sq.push_back('{cyc + 1, f, v});
    endtask

    task automatic drv(input logic s, input logic [63:0] d, input logic [5:0] de,
                       input logic t, input logic c);
        @(posedge clk);
        #1;
        a_send = s; a_data = d; a_dest = de; a_tail = t; a_crin = c;
        if (s) fqa.push_back('{cyc + 2, d, de, t});
        if (c) cqa.push_back(cyc + 2);
    endtask

    task automatic idle();
        drv(1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic drvb(input logic s, input logic [63:0] d, input logic [5:0] de,
                        input logic t, input logic c);
        @(posedge clk);
        #1;
        b_send = s; b_data = d; b_dest = de; b_tail = t; b_crin = c;
        if (s) fqb.push_back('{cyc, d, de, t});
        if (c) cqb.push_back(cyc);
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        a_send = 0; a_data = '0; a_dest = '0; a_tail = 0; a_crin = 0;
        b_send = 0; b_data = '0; b_dest = '0; b_tail = 0; b_crin = 0;
        fqa.delete(); fqb.delete(); cqa.delete(); cqb.delete(); sq.delete();
        push_next(0, 2);  push_next(1, 0);  push_next(2, 0);  push_next(3, 0);
        push_next(4, 0);  push_next(5, 0);  push_next(6, 0);  push_next(7, 0);
        push_next(8, 0);  push_next(9, 0);  push_next(10, 0); push_next(11, 0);
        push_next(12, 0); push_next(13, 2); push_next(14, 0); push_next(15, 0);
        push_next(16, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_pulse();

        // T1: two-cycle latency on both paths
        drv(1, 64'hA5, 6'd3, 1, 0);
        push_next(0, 1); push_next(2, 1); push_next(3, 1); push_next(1, 0);
        repeat (4) idle();
        drv(0, 64'd0, 6'd0, 0, 1);
        idle();
        idle();
        push_next(0, 2);
        idle();
        push_next(5, 0); push_next(4, 0);

        // T2: credits drain to zero, then underflow
        drv(1, 64'h11, 6'd1, 0, 0); push_next(1, 1); push_next(0, 1);
        drv(1, 64'h22, 6'd2, 0, 0); push_next(0, 0); push_next(4, 0);
        drv(1, 64'h33, 6'd3, 0, 0); push_next(0, 0); push_next(4, 1); push_next(2, 4); push_next(1, 1);
        drv(0, 64'd0, 6'd0, 0, 1);
        idle();
        idle(); push_next(0, 1);
        idle();

        // T3: simultaneous send+credit at zero, overflow at full
        rst_pulse();
        drv(1, 64'h44, 6'd4, 1, 1); push_next(0, 1);
        drv(1, 64'h55, 6'd5, 1, 0); push_next(0, 0);
        drv(1, 64'h66, 6'd6, 1, 0); push_next(0, 0); push_next(4, 0); push_next(3, 3);
        drv(0, 64'd0, 6'd0, 0, 1);
        drv(0, 64'd0, 6'd0, 0, 1);
        drv(0, 64'd0, 6'd0, 0, 1); push_next(0, 1);
        idle(); push_next(0, 2); push_next(5, 0);
        idle(); push_next(0, 2); push_next(5, 1);
        idle(); push_next(4, 0); push_next(5, 1);
        idle();

        // T4: 4-flit packet then single-flit packet
        rst_pulse();
        drv(1, 64'h100, 6'd7, 0, 0); sq.push_back('{cyc, 1, 0}); push_next(1, 1);
        drv(1, 64'h101, 6'd7, 0, 0); push_next(1, 1);
        drv(1, 64'h102, 6'd7, 0, 0);
        drv(1, 64'h103, 6'd7, 1, 0); push_next(1, 0);
        drv(1, 64'h104, 6'd8, 1, 0); push_next(1, 0); push_next(2, 5); push_next(3, 2);
        idle();
        idle();

        // T5: reset with traffic in both pipelines
        drv(1, 64'h77, 6'd9, 0, 1);
        drv(1, 64'h88, 6'd10, 1, 1);
        rst_pulse();
        idle(); push_next(0, 2); push_next(2, 0); push_next(4, 0);
        repeat (4) idle();

        // T6: zero-stage link, 4-bit counter wrap
        rst_pulse();
        for (int i = 1; i <= 17; i++) begin
            drvb(1, 64'(i) + 64'h1000, 6'(i), 1, (i % 3) == 0);
            if (i == 15) push_next(11, 15);
            if (i == 16) push_next(11, 0);
        end
        push_next(11, 1); push_next(12, 1);
        drvb(0, 64'd0, 6'd0, 0, 0);
        repeat (3) idle();

        checks++;
        if (fqa.size() != 0 || cqa.size() != 0) begin
            errors++;
            $display("FAIL drain_a: pending flits %0d credits %0d, want 0 0", fqa.size(), cqa.size());
        end
        checks++;
        if (fqb.size() != 0 || cqb.size() != 0) begin
            errors++;
            $display("FAIL drain_b: pending flits %0d credits %0d, want 0 0", fqb.size(), cqb.size());
        end
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL status_drain: pending %0d, want 0", sq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
